// File: rtl/stim_pkg.sv
// Shared types for the stimulus sequencer: FSM states, table entry layout.
// Entry widths match the generator's phase-step and dwell ports.
package stim_pkg;

    localparam int STIM_STEP_W  = 16;
    localparam int STIM_DWELL_W = 24;

    localparam logic [STIM_STEP_W-1:0] PHASE_48K = 16'd1042;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } stim_state_e;

    typedef struct packed {
        logic                    sel;
        logic [1:0]              gain;
        logic [STIM_STEP_W-1:0]  phase_step;
        logic [STIM_DWELL_W-1:0] dwell;
    } stim_entry_t;

    // Dwell 0 behaves as 1, so the counter preload never underflows
    function automatic logic [STIM_DWELL_W-1:0] dwell_init(
        input logic [STIM_DWELL_W-1:0] d
    );
        return (d == '0) ? '0 : d - 1'b1;
    endfunction

endpackage

// File: rtl/stim_table.sv
// Step table: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module stim_table
    import stim_pkg::*;
#(
    parameter  int NUM_STEPS = 8,
    localparam int AW        = $clog2(NUM_STEPS)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  stim_entry_t   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output stim_entry_t   o_rdata
);

    stim_entry_t mem [NUM_STEPS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/stim_sequencer.sv
// Steps the stimulus generator's controls through a programmed table,
// holding each entry for its dwell time.
module stim_sequencer
    import stim_pkg::*;
#(
    parameter  int NUM_STEPS   = 8,
    parameter  int DWELL_WIDTH = 24,
    parameter  int STEP_WIDTH  = 16,
    localparam int AW          = $clog2(NUM_STEPS)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_cfg_we,
    input  logic [AW-1:0]          i_cfg_addr,
    input  logic                   i_cfg_sel,
    input  logic [1:0]             i_cfg_gain,
    input  logic [STEP_WIDTH-1:0]  i_cfg_phase_step,
    input  logic [DWELL_WIDTH-1:0] i_cfg_dwell,
    input  logic [AW:0]            i_num_steps,
    input  logic                   i_loop,
    input  logic                   i_restart_en,
    input  logic                   i_start,
    input  logic                   i_abort,
    output logic                   o_sel,
    output logic [1:0]             o_noise_gain,
    output logic [STEP_WIDTH-1:0]  o_phase_step,
    output logic                   o_gen_rst_n,
    output logic [AW-1:0]          o_step_idx,
    output logic                   o_step_strobe,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam logic [AW:0] N_MAX = (AW+1)'(NUM_STEPS);

    stim_state_e            state;
    stim_state_e            state_nxt;
    logic [AW-1:0]          idx;
    logic [DWELL_WIDTH-1:0] cnt;
    logic [AW:0]            n_eff;
    logic                   last_step;
    logic                   expire;
    logic                   abort_hit;
    stim_entry_t            wr_entry;
    stim_entry_t            rd_entry;

    assign wr_entry = '{
        sel:        i_cfg_sel,
        gain:       i_cfg_gain,
        phase_step: i_cfg_phase_step,
        dwell:      i_cfg_dwell
    };

    stim_table #(
        .NUM_STEPS (NUM_STEPS)
    ) u_table (
        .i_clk   (i_clk),
        .i_we    (i_cfg_we),
        .i_waddr (i_cfg_addr),
        .i_wdata (wr_entry),
        .i_raddr (idx),
        .o_rdata (rd_entry)
    );

    assign n_eff     = (i_num_steps > N_MAX) ? N_MAX : i_num_steps;
    // Also true if the step count shrinks below idx mid-run
    assign last_step = ({1'b0, idx} + 1'b1) >= n_eff;
    assign expire    = (state == RUN) && (cnt == '0);
    assign abort_hit = i_abort && (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort_hit) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (i_start) state_nxt = (n_eff == '0) ? DONE : LOAD;
                LOAD: state_nxt = RUN;
                RUN:  if (expire) state_nxt = (!last_step || i_loop) ? LOAD : DONE;
                DONE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            idx           <= '0;
            cnt           <= '0;
            o_sel         <= 1'b0;
            o_noise_gain  <= '0;
            o_phase_step  <= '0;
            o_step_strobe <= 1'b0;
        end else begin
            o_step_strobe <= 1'b0;
            if (abort_hit) begin
                o_sel        <= 1'b0;
                o_noise_gain <= '0;
                o_phase_step <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (state_nxt == LOAD) idx <= '0;
                    end
                    LOAD: begin
                        o_sel         <= rd_entry.sel;
                        o_noise_gain  <= rd_entry.gain;
                        o_phase_step  <= rd_entry.phase_step;
                        cnt           <= dwell_init(rd_entry.dwell);
                        o_step_strobe <= 1'b1;
                    end
                    RUN: begin
                        if (!expire) begin
                            cnt <= cnt - 1'b1;
                        end else if (state_nxt == LOAD) begin
                            idx <= last_step ? '0 : idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        o_busy      = (state == LOAD) || (state == RUN);
        o_done      = (state == DONE) && !i_abort;
        o_gen_rst_n = !((state == LOAD) && i_restart_en && !i_abort);
        o_step_idx  = idx;
    end

endmodule

// File: tb/tb_stim_sequencer.sv
// Cycle-accurate scoreboard bench: per-cycle input/expected records are
// queued from the step timing rules, then replayed and compared.
module tb_stim_sequencer;
    import stim_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic        cfg_sel;
    logic [1:0]  cfg_gain;
    logic [15:0] cfg_phase;
    logic [23:0] cfg_dwell;
    logic [3:0]  num_steps;
    logic        loop_en;
    logic        restart_en;
    logic        start;
    logic        abort;
    logic        sel;
    logic [1:0]  gain;
    logic [15:0] phase;
    logic        gen_rst_n;
    logic [2:0]  step_idx;
    logic        strobe;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    stim_sequencer dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_cfg_we         (cfg_we),
        .i_cfg_addr       (cfg_addr),
        .i_cfg_sel        (cfg_sel),
        .i_cfg_gain       (cfg_gain),
        .i_cfg_phase_step (cfg_phase),
        .i_cfg_dwell      (cfg_dwell),
        .i_num_steps      (num_steps),
        .i_loop           (loop_en),
        .i_restart_en     (restart_en),
        .i_start          (start),
        .i_abort          (abort),
        .o_sel            (sel),
        .o_noise_gain     (gain),
        .o_phase_step     (phase),
        .o_gen_rst_n      (gen_rst_n),
        .o_step_idx       (step_idx),
        .o_step_strobe    (strobe),
        .o_busy           (busy),
        .o_done           (done)
    );

    typedef struct {
        string       name;
        logic        rst_n;
        logic        we;
        logic [2:0]  wa;
        stim_entry_t wd;
        logic [3:0]  n;
        logic        lp;
        logic        rs;
        logic        start;
        logic        abort;
        logic [25:0] exp;
    } rec_t;

    typedef struct {
        int          a;
        stim_entry_t e;
    } wr_t;

    typedef struct {
        logic [3:0] n;
        logic       rs;
        int         first_wr;
        int         num_wr;
    } case_t;

    rec_t        q[$];
    stim_entry_t model [8];
    logic        hs;
    logic [1:0]  hg;
    logic [15:0] hp;
    logic [2:0]  hidx;
    logic [3:0]  cur_n;
    logic        cur_lp;
    logic        cur_rs;
    int          passed = 0;
    int          total  = 0;

    function automatic stim_entry_t mke(logic s, logic [1:0] g,
                                        logic [15:0] p, logic [23:0] d);
        stim_entry_t e;
        e.sel        = s;
        e.gain       = g;
        e.phase_step = p;
        e.dwell      = d;
        return e;
    endfunction

    function automatic logic [25:0] ex(logic s, logic [1:0] g,
                                       logic [15:0] p, logic gn,
                                       logic [2:0] i, logic st,
                                       logic b, logic dn);
        return {s, g, p, gn, i, st, b, dn};
    endfunction

    function automatic rec_t mk(string name, logic [25:0] e);
        rec_t r;
        r.name  = name;
        r.rst_n = 1'b1;
        r.we    = 1'b0;
        r.wa    = '0;
        r.wd    = '0;
        r.n     = cur_n;
        r.lp    = cur_lp;
        r.rs    = cur_rs;
        r.start = 1'b0;
        r.abort = 1'b0;
        r.exp   = e;
        return r;
    endfunction

    function automatic logic [25:0] held_idle();
        return ex(hs, hg, hp, 1'b1, hidx, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic push_write(input int a, input stim_entry_t e);
        rec_t r;
        r    = mk("cfg_wr", held_idle());
        r.we = 1'b1;
        r.wa = a[2:0];
        r.wd = e;
        q.push_back(r);
        model[a] = e;
    endtask

    task automatic push_start();
        rec_t r;
        r       = mk("start", held_idle());
        r.start = 1'b1;
        q.push_back(r);
    endtask

    task automatic push_step(input int s, input int st_at, input int ab_at,
                             input int wr_at, input int wa,
                             input stim_entry_t wd);
        rec_t        r;
        stim_entry_t e;
        logic [2:0]  si;
        int          d;
        si = s[2:0];
        e  = model[s];
        d  = (e.dwell == '0) ? 1 : int'(e.dwell);
        r  = mk("load", ex(hs, hg, hp, ~cur_rs, si, 1'b0, 1'b1, 1'b0));
        q.push_back(r);
        hidx = si;
        for (int k = 0; k < d; k++) begin
            r = mk("run", ex(e.sel, e.gain, e.phase_step, 1'b1, si,
                             k == 0, 1'b1, 1'b0));
            r.start = (k == st_at);
            r.abort = (k == ab_at);
            if (k == wr_at) begin
                r.we = 1'b1;
                r.wa = wa[2:0];
                r.wd = wd;
            end
            q.push_back(r);
        end
        hs = e.sel;
        hg = e.gain;
        hp = e.phase_step;
        if (wr_at >= 0) model[wa] = wd;
    endtask

    task automatic push_done();
        q.push_back(mk("done", ex(hs, hg, hp, 1'b1, hidx, 1'b0, 1'b0, 1'b1)));
        q.push_back(mk("idle_after", held_idle()));
    endtask

    task automatic run_q();
        rec_t        r;
        logic [25:0] got;
        while (q.size() > 0) begin
            r          = q.pop_front();
            rst_n      = r.rst_n;
            cfg_we     = r.we;
            cfg_addr   = r.wa;
            cfg_sel    = r.wd.sel;
            cfg_gain   = r.wd.gain;
            cfg_phase  = r.wd.phase_step;
            cfg_dwell  = r.wd.dwell;
            num_steps  = r.n;
            loop_en    = r.lp;
            restart_en = r.rs;
            start      = r.start;
            abort      = r.abort;
            @(negedge clk);
            got = {sel, gain, phase, gen_rst_n, step_idx, strobe, busy, done};
            total++;
            if (got === r.exp) begin
                passed++;
            end else begin
                $display("FAIL %s t=%0t got %h exp %h (sel,gain,phase,gen_rst_n,idx,strobe,busy,done)",
                         r.name, $time, got, r.exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    wr_t   wtab [11];
    case_t ctab [4];

    initial begin
        rec_t r;
        int   neff;

        rst_n = 1'b0; start = 1'b1; abort = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_sel = 1'b0; cfg_gain = '0;
        cfg_phase = '0; cfg_dwell = '0; num_steps = 4'd2;
        loop_en = 1'b0; restart_en = 1'b1;
        hs = 1'b0; hg = '0; hp = '0; hidx = '0;
        cur_n = 4'd2; cur_lp = 1'b0; cur_rs = 1'b1;

        wtab[0] = '{0, mke(1'b1, 2'd0, PHASE_48K, 24'd5)};
        wtab[1] = '{1, mke(1'b0, 2'd2, 16'd100, 24'd3)};
        wtab[2] = '{0, mke(1'b0, 2'd1, 16'd555, 24'd0)};
        for (int i = 0; i < 8; i++) begin
            wtab[3+i] = '{i, mke(i[0], i[1:0], 16'(200 + i), 24'(i % 3))};
        end
        ctab[0] = '{4'd2,  1'b1, 0, 2};
        ctab[1] = '{4'd1,  1'b0, 2, 1};
        ctab[2] = '{4'd0,  1'b1, 0, 0};
        ctab[3] = '{4'd15, 1'b1, 3, 8};

        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            r       = mk("reset", ex(1'b0, 2'd0, 16'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0));
            r.rst_n = 1'b0;
            r.start = 1'b1;
            q.push_back(r);
        end
        for (int i = 0; i < 2; i++) begin
            q.push_back(mk("released_idle", held_idle()));
        end
        run_q();

        for (int c = 0; c < 4; c++) begin
            cur_n  = ctab[c].n;
            cur_rs = ctab[c].rs;
            cur_lp = 1'b0;
            for (int w = 0; w < ctab[c].num_wr; w++) begin
                push_write(wtab[ctab[c].first_wr + w].a,
                           wtab[ctab[c].first_wr + w].e);
            end
            push_start();
            neff = (ctab[c].n > 4'd8) ? 8 : int'(ctab[c].n);
            for (int s = 0; s < neff; s++) begin
                push_step(s, -1, -1, -1, 0, '0);
            end
            push_done();
            run_q();
        end

        cur_n = 4'd2; cur_rs = 1'b0; cur_lp = 1'b1;
        push_write(0, mke(1'b1, 2'd1, 16'd300, 24'd4));
        push_write(1, mke(1'b0, 2'd3, 16'd400, 24'd4));
        push_start();
        push_step(0, -1, -1, -1, 0, '0);
        push_step(1, -1, -1, -1, 0, '0);
        push_step(0, -1, -1, -1, 0, '0);
        cur_lp = 1'b0;
        push_step(1, -1, -1, -1, 0, '0);
        push_done();
        run_q();

        cur_n = 4'd2; cur_rs = 1'b1; cur_lp = 1'b0;
        push_write(0, mke(1'b1, 2'd2, 16'd777, 24'd5));
        push_write(1, mke(1'b0, 2'd1, 16'd50, 24'd3));
        push_start();
        push_step(0, 1, 4, -1, 0, '0);
        hs = 1'b0; hg = '0; hp = '0;
        for (int i = 0; i < 3; i++) begin
            q.push_back(mk("abort_idle", held_idle()));
        end
        run_q();

        cur_n = 4'd2; cur_rs = 1'b0; cur_lp = 1'b0;
        push_write(0, mke(1'b0, 2'd0, 16'd900, 24'd4));
        push_write(1, mke(1'b1, 2'd1, 16'd11, 24'd2));
        push_start();
        push_step(0, -1, -1, 2, 1, mke(1'b1, 2'd3, 16'd222, 24'd3));
        push_step(1, -1, -1, -1, 0, '0);
        push_done();
        run_q();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
